// File: rtl/elevator_pkg.sv
// Shared types for the elevator direction-decision block.
// ELEV_CTRL_REVERSE_GUARD_EN adds the S_HALT state used between direct reversals.
package elevator_pkg;

    localparam int FLOOR_W_DEFAULT = 4;

    typedef logic [FLOOR_W_DEFAULT-1:0] floor_t;

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_UP       = 3'd1,
        S_DOWN     = 3'd2,
        S_AT_FLOOR = 3'd3,
`ifdef ELEV_CTRL_REVERSE_GUARD_EN
        S_FAULT    = 3'd4,
        S_HALT     = 3'd5
`else
        S_FAULT    = 3'd4
`endif
    } ctrl_state_t;

endpackage

// File: rtl/elevator_floor_cmp.sv
// Combinational comparison of target vs current floor, with range check against max_floor.
module elevator_floor_cmp #(
    parameter int FLOOR_W = 4
) (
    input  logic [FLOOR_W-1:0] floor_no,
    input  logic [FLOOR_W-1:0] current_floor,
    input  logic [FLOOR_W-1:0] max_floor,
    output logic               gt,
    output logic               lt,
    output logic               eq,
    output logic               err
);

    // Plain unsigned compares at full width; no wrap-around is possible.
    always_comb begin
        gt  = floor_no > current_floor;
        lt  = floor_no < current_floor;
        eq  = floor_no == current_floor;
        err = (floor_no > max_floor) || (current_floor > max_floor);
    end

endmodule

// File: rtl/elevator_ctrl.sv
// Registered up/down/at-floor/fault decision for the elevator motion FSM.
// Optional ELEV_CTRL_REVERSE_GUARD_EN inserts a one-cycle S_HALT on direct reversals.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOOR_W   = FLOOR_W_DEFAULT,
    parameter int MAX_FLOOR = 9
) (
    input  logic               i_ctrl_clk,
    input  logic               i_ctrl_rst,
    input  logic [FLOOR_W-1:0] i_ctrl_floor_no,
    input  logic [FLOOR_W-1:0] i_ctrl_current_floor,
    output logic               o_ctrl_fsm_move_up,
    output logic               o_ctrl_fsm_move_down,
    output logic               o_ctrl_fsm_equal,
    output logic               o_ctrl_req_err,
    output ctrl_state_t        o_ctrl_state
);

    // No handshake: both floor inputs are levels sampled on every rising edge;
    // outputs are a pure decode of the state register and change one edge later.

    localparam logic [FLOOR_W-1:0] MAX_FLOOR_V = MAX_FLOOR[FLOOR_W-1:0];

    ctrl_state_t state, state_next, cand;
    logic        cmp_gt, cmp_lt, cmp_eq, cmp_err;

    elevator_floor_cmp #(
        .FLOOR_W(FLOOR_W)
    ) u_cmp (
        .floor_no      (i_ctrl_floor_no),
        .current_floor (i_ctrl_current_floor),
        .max_floor     (MAX_FLOOR_V),
        .gt            (cmp_gt),
        .lt            (cmp_lt),
        .eq            (cmp_eq),
        .err           (cmp_err)
    );

    always_ff @(posedge i_ctrl_clk) begin
        if (i_ctrl_rst) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        cand = S_AT_FLOOR;
        if (cmp_err) begin
            cand = S_FAULT;
        end else if (cmp_gt) begin
            cand = S_UP;
        end else if (cmp_lt) begin
            cand = S_DOWN;
        end else if (cmp_eq) begin
            cand = S_AT_FLOOR;
        end

        state_next = cand;
`ifdef ELEV_CTRL_REVERSE_GUARD_EN
        // Fault already wins inside cand, so only true direction flips are held.
        if ((state == S_UP && cand == S_DOWN) || (state == S_DOWN && cand == S_UP)) begin
            state_next = S_HALT;
        end
`endif
    end

    always_comb begin
        o_ctrl_fsm_move_up   = 1'b0;
        o_ctrl_fsm_move_down = 1'b0;
        o_ctrl_fsm_equal     = 1'b0;
        o_ctrl_req_err       = 1'b0;
        case (state)
            S_UP:       o_ctrl_fsm_move_up   = 1'b1;
            S_DOWN:     o_ctrl_fsm_move_down = 1'b1;
            S_AT_FLOOR: o_ctrl_fsm_equal     = 1'b1;
            S_FAULT:    o_ctrl_req_err       = 1'b1;
            default:    ;
        endcase
    end

    assign o_ctrl_state = state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed self-checking bench for elevator_ctrl (FLOOR_W=4, MAX_FLOOR=9).
module tb_elevator_ctrl;
    import elevator_pkg::*;

    localparam logic [3:0] O_NONE = 4'b0000;
    localparam logic [3:0] O_UP   = 4'b1000;
    localparam logic [3:0] O_DOWN = 4'b0100;
    localparam logic [3:0] O_EQ   = 4'b0010;
    localparam logic [3:0] O_ERR  = 4'b0001;

    logic        clk;
    logic        rst;
    logic [3:0]  floor_no;
    logic [3:0]  current_floor;
    logic        move_up;
    logic        move_down;
    logic        equal;
    logic        req_err;
    ctrl_state_t dbg_state;

    int checks;
    int errors;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    elevator_ctrl #(
        .FLOOR_W   (4),
        .MAX_FLOOR (9)
    ) dut (
        .i_ctrl_clk           (clk),
        .i_ctrl_rst           (rst),
        .i_ctrl_floor_no      (floor_no),
        .i_ctrl_current_floor (current_floor),
        .o_ctrl_fsm_move_up   (move_up),
        .o_ctrl_fsm_move_down (move_down),
        .o_ctrl_fsm_equal     (equal),
        .o_ctrl_req_err       (req_err),
        .o_ctrl_state         (dbg_state)
    );

    // driver: apply levels just after an edge, then let one edge capture them
    task automatic drive(input logic r, input logic [3:0] f, input logic [3:0] c);
        rst           = r;
        floor_no      = f;
        current_floor = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard check of {up, down, equal, err}
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {move_up, move_down, equal, req_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input ctrl_state_t exp);
        checks++;
        assert (dbg_state === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 4'd0, 4'd0);
        tick();
        check("reset_outputs", O_NONE);
        check_state("reset_state", S_RESET);

        drive(1'b0, 4'd0, 4'd0);
        tick();
        check("release_at_floor", O_EQ);
        tick();
        check("hold_at_floor", O_EQ);

        drive(1'b0, 4'd1, 4'd4);
        #2;
        check("no_comb_path", O_EQ);
        tick();
        check("down_1_from_4", O_DOWN);

        drive(1'b0, 4'd1, 4'd1);
        tick();
        check("down_to_equal", O_EQ);

        drive(1'b0, 4'd7, 4'd2);
        tick();
        check("up_7_from_2", O_UP);

        drive(1'b0, 4'd0, 4'd9);
        tick();
`ifdef ELEV_CTRL_REVERSE_GUARD_EN
        check("reverse_halt", O_NONE);
        check_state("reverse_halt_state", S_HALT);
        tick();
`endif
        check("reverse_to_down", O_DOWN);

        drive(1'b0, 4'd12, 4'd3);
        tick();
        check("err_floor_no_12", O_ERR);

        drive(1'b0, 4'd3, 4'd10);
        tick();
        check("err_current_10", O_ERR);

        drive(1'b0, 4'd9, 4'd9);
        tick();
        check("fault_to_equal_9", O_EQ);

        drive(1'b0, 4'd15, 4'd15);
        tick();
        check("err_both_15", O_ERR);

        drive(1'b0, 4'd10, 4'd0);
        tick();
        check("err_first_invalid", O_ERR);

        drive(1'b0, 4'd9, 4'd0);
        tick();
        check("up_max_from_0", O_UP);

        // fault from an up state takes priority over any reversal guard
        drive(1'b0, 4'd2, 4'd11);
        tick();
        check("up_to_err", O_ERR);

        drive(1'b0, 4'd5, 4'd6);
        tick();
        check("down_5_from_6", O_DOWN);

        drive(1'b0, 4'd6, 4'd5);
        tick();
`ifdef ELEV_CTRL_REVERSE_GUARD_EN
        check("reverse_halt_2", O_NONE);
        // successor of halt follows the inputs sampled on the next edge
        drive(1'b0, 4'd4, 4'd4);
        tick();
        check("halt_to_equal", O_EQ);
        drive(1'b0, 4'd6, 4'd5);
        tick();
`endif
        check("up_6_from_5", O_UP);

        drive(1'b1, 4'd6, 4'd5);
        tick();
        check("mid_reset", O_NONE);
        drive(1'b1, 4'd0, 4'd9);
        tick();
        check("reset_ignores_inputs", O_NONE);

        drive(1'b0, 4'd8, 4'd3);
        tick();
        check("resume_up", O_UP);

        drive(1'b0, 4'd0, 4'd0);
        tick();
`ifdef ELEV_CTRL_REVERSE_GUARD_EN
        check("up_to_equal_guard", O_EQ);
`else
        check("up_to_equal", O_EQ);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
